adc_axis_framer: RTL and testbench

ADC_AXIS_FRAMER -- requirements
Module: adc_axis_framer

---
 rtl/adc_framer_pkg.sv | 35 +++
 rtl/axis_sync_fifo.sv | 66 ++++++
 rtl/adc_axis_framer.sv | 191 +++++++++++++++++++
 tb/tb_adc_axis_framer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_framer_pkg.sv
`default_nettype none
// ============================================================================
// adc_framer_pkg : shared FSM type, beat constants and tkeep helper  (rev 1.0)
// ============================================================================
package adc_framer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_FLUSH   = 2'd2
   } framer_state_t;

   localparam int MAX_KEEP_W = 128;
   localparam int DEF_KEEP_W = 8;

   function automatic int samples_per_beat(input int data_w, input int in_w);
      return data_w / in_w;
   endfunction

   function automatic int keep_width(input int data_w);
      return data_w / 8;
   endfunction

   function automatic logic [MAX_KEEP_W-1:0] tkeep_from_count(input int count,
                                                              input int bytes_per_sample);
      logic [MAX_KEEP_W-1:0] keep;
      keep = '0;
      for (int i = 0; i < MAX_KEEP_W; i++) begin
         keep[i] = (i < count * bytes_per_sample);
      end
      return keep;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_sync_fifo.sv
`default_nettype none
// ============================================================================
// axis_sync_fifo : single-clock first-word-fall-through beat FIFO  (rev 1.0)
// ============================================================================
module axis_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_full;
   logic             w_push;
   logic             w_pop;

   assign w_full    = (r_count == (AW+1)'(DEPTH));
   assign out_valid = (r_count != '0);
   // A full FIFO still accepts a write when the head is leaving this cycle.
   assign in_ready  = ~w_full | out_ready;
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;
   assign out_data  = out_valid ? mem[r_rd_ptr] : '0;
   assign level     = r_count;

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/adc_axis_framer.sv
`default_nettype none
// ============================================================================
// adc_axis_framer : packs ADC samples into AXI-Stream beats with framing  (rev 1.0)
// ============================================================================
module adc_axis_framer
   import adc_framer_pkg::*;
#(
   parameter int NUM_CH             = 2,
   parameter int SAMPLE_WIDTH       = 16,
   parameter int ADC_AXI_DATA_WIDTH = DEF_KEEP_W * 8,
   parameter int FIFO_DEPTH         = 512
) (
   input  logic                                aclk,
   input  logic                                aresetn,
   input  logic [NUM_CH*SAMPLE_WIDTH-1:0]      sample_data,
   input  logic                                sample_valid,
   input  logic                                capture_en,
   input  logic [15:0]                         pkt_len,
   output logic [ADC_AXI_DATA_WIDTH-1:0]       axis_adc_tdata,
   output logic [ADC_AXI_DATA_WIDTH/8-1:0]     axis_adc_tkeep,
   output logic                                axis_adc_tvalid,
   output logic                                axis_adc_tlast,
   output logic                                axis_adc_tuser,
   input  logic                                axis_adc_tready,
   output logic                                capture_active,
   output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
   output logic [15:0]                         overflow_count,
   output logic                                overflow_sticky,
   input  logic                                clear_status
);

   localparam int IN_WIDTH = NUM_CH * SAMPLE_WIDTH;
   localparam int R        = samples_per_beat(ADC_AXI_DATA_WIDTH, IN_WIDTH);
   localparam int KEEP_W   = keep_width(ADC_AXI_DATA_WIDTH);
   localparam int CNT_W    = (R > 1) ? $clog2(R) : 1;
   localparam int FIFO_W   = ADC_AXI_DATA_WIDTH + KEEP_W + 2;

   framer_state_t                 r_state;
   framer_state_t                 w_state_nxt;
   logic [ADC_AXI_DATA_WIDTH-1:0] r_pack_data;
   logic [CNT_W-1:0]              r_pack_cnt;
   logic [15:0]                   r_pkt_len;
   logic [15:0]                   r_beat_cnt;
   logic                          r_open;
   logic                          r_drop_pend;
   logic [15:0]                   r_ovf_cnt;
   logic                          r_ovf_sticky;

   logic                          w_accept;
   logic                          w_beat_done;
   logic                          w_last_beat;
   logic                          w_drop;
   logic                          w_flush_need;
   logic [ADC_AXI_DATA_WIDTH-1:0] w_full_beat;
   logic                          w_fifo_ready;
   logic                          w_push;
   logic [ADC_AXI_DATA_WIDTH-1:0] w_push_data;
   logic [KEEP_W-1:0]             w_push_keep;
   logic                          w_push_last;
   logic                          w_push_user;
   logic [FIFO_W-1:0]             w_fifo_out;

   assign w_accept     = (r_state == ST_CAPTURE) & capture_en & sample_valid;
   assign w_beat_done  = w_accept & (r_pack_cnt == CNT_W'(R - 1));
   assign w_full_beat  = r_pack_data
                       | (ADC_AXI_DATA_WIDTH'(sample_data) << (r_pack_cnt * IN_WIDTH));
   assign w_last_beat  = (r_pkt_len != 16'd0) && ((r_beat_cnt + 16'd1) == r_pkt_len);
   assign w_drop       = w_beat_done & ~w_fifo_ready;
   assign w_flush_need = (r_pack_cnt != '0) | r_open;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_push_data = '0;
      w_push_keep = '0;
      w_push_last = 1'b0;
      w_push_user = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (capture_en) begin
               w_state_nxt = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (!capture_en) begin
               w_state_nxt = ST_FLUSH;
            end else if (w_beat_done) begin
               w_push      = w_fifo_ready;
               w_push_data = w_full_beat;
               w_push_keep = '1;
               w_push_last = w_last_beat;
               w_push_user = r_drop_pend;
            end
         end
         ST_FLUSH: begin
            // Flush beat never drops: hold here until the FIFO has room.
            if (!w_flush_need) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_push      = w_fifo_ready;
               w_push_data = r_pack_data;
               w_push_keep = KEEP_W'(tkeep_from_count(int'(r_pack_cnt), IN_WIDTH / 8));
               w_push_last = 1'b1;
               w_push_user = r_drop_pend;
               if (w_fifo_ready) begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_pack_data  <= '0;
         r_pack_cnt   <= '0;
         r_pkt_len    <= '0;
         r_beat_cnt   <= '0;
         r_open       <= 1'b0;
         r_drop_pend  <= 1'b0;
         r_ovf_cnt    <= '0;
         r_ovf_sticky <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && capture_en) begin
            r_pkt_len  <= pkt_len;
            r_beat_cnt <= '0;
         end

         // Dropped beats still count toward packet length.
         if (w_beat_done) begin
            r_pack_data <= '0;
            r_pack_cnt  <= '0;
            r_beat_cnt  <= w_last_beat ? 16'd0 : r_beat_cnt + 16'd1;
         end else if (w_accept) begin
            r_pack_data <= w_full_beat;
            r_pack_cnt  <= r_pack_cnt + 1'b1;
         end else if (r_state == ST_FLUSH && w_push) begin
            r_pack_data <= '0;
            r_pack_cnt  <= '0;
         end

         if (w_push) begin
            r_open      <= ~w_push_last;
            r_drop_pend <= 1'b0;
         end else if (w_drop) begin
            r_drop_pend <= 1'b1;
         end

         if (clear_status) begin
            r_ovf_cnt    <= '0;
            r_ovf_sticky <= 1'b0;
         end else if (w_drop) begin
            r_ovf_sticky <= 1'b1;
            if (r_ovf_cnt != 16'hFFFF) begin
               r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
         end
      end
   end

   axis_sync_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (aclk),
      .rst_n     (aresetn),
      .in_data   ({w_push_user, w_push_last, w_push_keep, w_push_data}),
      .in_valid  (w_push),
      .in_ready  (w_fifo_ready),
      .out_data  (w_fifo_out),
      .out_valid (axis_adc_tvalid),
      .out_ready (axis_adc_tready),
      .level     (fifo_level)
   );

   assign {axis_adc_tuser, axis_adc_tlast, axis_adc_tkeep, axis_adc_tdata} = w_fifo_out;
   assign capture_active  = (r_state != ST_IDLE);
   assign overflow_count  = r_ovf_cnt;
   assign overflow_sticky = r_ovf_sticky;

endmodule
`default_nettype wire

// File: tb/tb_adc_axis_framer.sv
`default_nettype none
// ============================================================================
// tb_adc_axis_framer : directed bench, default DUT plus a 4-deep FIFO DUT  (rev 1.0)
// ============================================================================
module tb_adc_axis_framer;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic        u;
   } beat_t;

   logic        clk;
   logic        aresetn;
   logic [31:0] sample_data;
   logic        sample_valid;
   logic        capture_en;
   logic [15:0] pkt_len;
   logic        tready;
   logic        clear_status;

   logic [63:0] a_tdata,  b_tdata;
   logic [7:0]  a_tkeep,  b_tkeep;
   logic        a_tvalid, b_tvalid;
   logic        a_tlast,  b_tlast;
   logic        a_tuser,  b_tuser;
   logic        a_active, b_active;
   logic [9:0]  a_level;
   logic [2:0]  b_level;
   logic [15:0] a_ovf,    b_ovf;
   logic        a_sticky, b_sticky;

   int    n_checks = 0;
   int    n_err    = 0;
   beat_t qa[$];
   beat_t qb[$];
   beat_t cur_a, cur_b, a_prev;
   logic  a_stalled = 1'b0;

   assign cur_a = '{d: a_tdata, k: a_tkeep, l: a_tlast, u: a_tuser};
   assign cur_b = '{d: b_tdata, k: b_tkeep, l: b_tlast, u: b_tuser};

   adc_axis_framer u_a (
      .aclk(clk), .aresetn(aresetn), .sample_data(sample_data), .sample_valid(sample_valid),
      .capture_en(capture_en), .pkt_len(pkt_len),
      .axis_adc_tdata(a_tdata), .axis_adc_tkeep(a_tkeep), .axis_adc_tvalid(a_tvalid),
      .axis_adc_tlast(a_tlast), .axis_adc_tuser(a_tuser), .axis_adc_tready(tready),
      .capture_active(a_active), .fifo_level(a_level), .overflow_count(a_ovf),
      .overflow_sticky(a_sticky), .clear_status(clear_status)
   );

   adc_axis_framer #(.FIFO_DEPTH(4)) u_b (
      .aclk(clk), .aresetn(aresetn), .sample_data(sample_data), .sample_valid(sample_valid),
      .capture_en(capture_en), .pkt_len(pkt_len),
      .axis_adc_tdata(b_tdata), .axis_adc_tkeep(b_tkeep), .axis_adc_tvalid(b_tvalid),
      .axis_adc_tlast(b_tlast), .axis_adc_tuser(b_tuser), .axis_adc_tready(tready),
      .capture_active(b_active), .fifo_level(b_level), .overflow_count(b_ovf),
      .overflow_sticky(b_sticky), .clear_status(clear_status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] smp(input int i);
      return 32'(i + 1) << 16;
   endfunction

   function automatic beat_t mk(input logic [63:0] d, input logic [7:0] k,
                                input logic l, input logic u);
      return '{d: d, k: k, l: l, u: u};
   endfunction

   function automatic beat_t getq(input bit from_b, input int idx);
      if (from_b) return (idx < qb.size()) ? qb[idx] : '0;
      return (idx < qa.size()) ? qa[idx] : '0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d);
      sample_valid = 1'b1;
      sample_data  = d;
      tick();
      sample_valid = 1'b0;
   endtask

   // Beats are recorded mid-cycle when a handshake is pending at the next edge.
   always @(negedge clk) begin
      if (!aresetn) begin
         a_stalled = 1'b0;
      end else begin
         if (a_stalled) begin
            chk("stall_tvalid_held", a_tvalid, 1'b1);
            chk("stall_beat_stable", cur_a, a_prev);
         end
         if (a_tvalid && tready) qa.push_back(cur_a);
         if (b_tvalid && tready) qb.push_back(cur_b);
         a_stalled = a_tvalid && !tready;
         a_prev    = cur_a;
      end
   end

   initial begin
      aresetn = 1'b0; capture_en = 1'b0; sample_valid = 1'b0; sample_data = '0;
      pkt_len = '0;   tready = 1'b0;     clear_status = 1'b0;
      repeat (3) tick();
      chk("rst_tvalid", a_tvalid, 1'b0);
      chk("rst_tdata", a_tdata, 64'd0);
      chk("rst_keep_last_user", {a_tkeep, a_tlast, a_tuser}, 10'd0);
      chk("rst_level", a_level, 10'd0);
      chk("rst_active", a_active, 1'b0);
      chk("rst_ovf", {a_ovf, a_sticky}, 17'd0);
      aresetn = 1'b1;

      // Length framing, 16 samples, pkt_len = 4
      pkt_len = 16'd4; tready = 1'b1; capture_en = 1'b1;
      tick();
      chk("t1_active", a_active, 1'b1);
      send(smp(0));
      send(smp(1));
      chk("t1_latency_tvalid", a_tvalid, 1'b1);
      chk("t1_first_tdata", a_tdata, {smp(1), smp(0)});
      for (int i = 2; i < 16; i++) send(smp(i));
      capture_en = 1'b0;
      repeat (6) tick();
      chk("t1_idle", a_active, 1'b0);
      chk("t1_count_a", qa.size(), 8);
      chk("t1_count_b", qb.size(), 8);
      for (int j = 0; j < 8; j++)
         chk($sformatf("t1_beat%0d", j), getq(0, j),
             mk({smp(2*j+1), smp(2*j)}, 8'hFF, (j == 3 || j == 7), 1'b0));

      // Partial flush beat
      qa.delete(); qb.delete();
      pkt_len = 16'd0; capture_en = 1'b1;
      tick();
      for (int i = 20; i < 23; i++) send(smp(i));
      capture_en = 1'b0;
      repeat (5) tick();
      chk("t2_count", qa.size(), 2);
      chk("t2_beat0", getq(0, 0), mk({smp(21), smp(20)}, 8'hFF, 1'b0, 1'b0));
      chk("t2_partial", getq(0, 1), mk({32'd0, smp(22)}, 8'h0F, 1'b1, 1'b0));

      // Null beat closes an open packet
      qa.delete(); qb.delete();
      capture_en = 1'b1;
      tick();
      for (int i = 24; i < 28; i++) send(smp(i));
      capture_en = 1'b0;
      repeat (5) tick();
      chk("t3_count", qa.size(), 3);
      chk("t3_beat1", getq(0, 1), mk({smp(27), smp(26)}, 8'hFF, 1'b0, 1'b0));
      chk("t3_null", getq(0, 2), mk(64'd0, 8'h00, 1'b1, 1'b0));

      // Overflow on the 4-deep instance
      qa.delete(); qb.delete();
      tready = 1'b0; capture_en = 1'b1;
      tick();
      for (int i = 0; i < 12; i++) send(smp(32 + i));
      tick();
      chk("t4_b_level", b_level, 3'd4);
      chk("t4_b_ovf", b_ovf, 16'd2);
      chk("t4_b_sticky", b_sticky, 1'b1);
      chk("t4_a_level", a_level, 10'd6);
      chk("t4_a_ovf", {a_ovf, a_sticky}, 17'd0);
      chk("t4_b_head", b_tdata, {smp(33), smp(32)});
      tready = 1'b1;
      repeat (8) tick();
      chk("t4_b_drained", b_level, 3'd0);
      chk("t4_b_count", qb.size(), 4);
      for (int j = 0; j < 4; j++)
         chk($sformatf("t4_b_beat%0d", j), getq(1, j),
             mk({smp(33 + 2*j), smp(32 + 2*j)}, 8'hFF, 1'b0, 1'b0));
      send(smp(60));
      send(smp(61));
      capture_en = 1'b0;
      repeat (6) tick();
      chk("t4_b_total", qb.size(), 6);
      chk("t4_b_tuser_beat", getq(1, 4), mk({smp(61), smp(60)}, 8'hFF, 1'b0, 1'b1));
      chk("t4_b_null", getq(1, 5), mk(64'd0, 8'h00, 1'b1, 1'b0));
      chk("t4_a_total", qa.size(), 8);
      chk("t4_a_no_tuser", getq(0, 6), mk({smp(61), smp(60)}, 8'hFF, 1'b0, 1'b0));
      chk("t4_sticky_held", b_sticky, 1'b1);
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      chk("t4_clear", {b_ovf, b_sticky}, 17'd0);

      // Reset mid-packet with three beats queued
      qa.delete(); qb.delete();
      tready = 1'b0; pkt_len = 16'd8; capture_en = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) send(smp(70 + i));
      tick();
      chk("t5_level", a_level, 10'd3);
      @(posedge clk);
      #3;
      aresetn = 1'b0;
      #1;
      chk("t5_async_tvalid", a_tvalid, 1'b0);
      chk("t5_async_level", a_level, 10'd0);
      chk("t5_async_active", a_active, 1'b0);
      capture_en = 1'b0;
      @(posedge clk);
      #1;
      aresetn = 1'b1;
      tready  = 1'b1;
      repeat (6) tick();
      chk("t5_no_output", qa.size() + qb.size(), 0);

      // Random back-pressure, pkt_len = 2
      qa.delete(); qb.delete();
      pkt_len = 16'd2; capture_en = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         tready = 1'($urandom_range(0, 1));
         send(smp(80 + i));
      end
      capture_en = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tready = 1'($urandom_range(0, 1));
         tick();
      end
      tready = 1'b1;
      repeat (6) tick();
      chk("t6_count", qa.size(), 4);
      for (int j = 0; j < 4; j++)
         chk($sformatf("t6_beat%0d", j), getq(0, j),
             mk({smp(81 + 2*j), smp(80 + 2*j)}, 8'hFF, (j % 2 == 1), 1'b0));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
